// File: rtl/mcbsp0_rx_frame_ctrl.sv
// McBSP0 slave receive frame controller: header/payload parsing into a ping-pong buffer with pending/ack handoff.
// Optional trailing checksum word enabled by defining MCBSP0_RX_CHKSUM_EN.
module mcbsp0_rx_frame_ctrl #(
   parameter int         WORD_BITS   = 32,
   parameter int         MAX_WORDS   = 256,
   parameter int         TIMEOUT_CYC = 4096,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
   input  logic        mcbsp_slaver_clkx,
   input  logic        mcbsp_slaver_rst,
   input  logic [31:0] rx_data_in,
   input  logic        rx_vaild_in,
   output logic [6:0]  rx_reg_length,
   input  logic        frame_ack,
   output logic        buf_wr_en,
   output logic [9:0]  buf_wr_addr,
   output logic [31:0] buf_wr_data,
   output logic        frame_done,
   output logic        frame_bank,
   output logic [7:0]  frame_type,
   output logic [8:0]  frame_words,
   output logic        frame_pending,
   output logic        err_hdr,
   output logic        err_timeout,
   output logic        err_chksum,
   output logic        err_overrun,
   output logic [31:0] debug_signal
);

   // state     | meaning
   // S_IDLE    | waiting for a header word
   // S_PAYLOAD | writing payload words into the current write bank
   // S_CHECK   | waiting for the trailing checksum word (checksum build only)
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PAYLOAD = 3'd1
`ifdef MCBSP0_RX_CHKSUM_EN
      ,S_CHECK  = 3'd2
`endif
   } state_t;

   localparam logic [8:0]  MAX_N  = 9'(MAX_WORDS);
   localparam logic [17:0] TMO_TC = 18'(TIMEOUT_CYC - 1);

   state_t      state;
   logic [8:0]  idx;
   logic [8:0]  n_words;
   logic [7:0]  cur_type;
   logic        wr_bank;
   logic [17:0] timeout_cnt;
`ifdef MCBSP0_RX_CHKSUM_EN
   logic [31:0] xor_acc;
`endif

   logic hdr_ok;
   logic last_word;
   logic complete_c;
   logic pend_busy;

   assign rx_reg_length = 7'(WORD_BITS);
   assign hdr_ok        = (rx_data_in[31:24] == SYNC_BYTE) && (rx_data_in[8:0] != 9'd0) &&
                          (rx_data_in[8:0] <= MAX_N);
   assign last_word     = (idx == (n_words - 9'd1));
   // An ack landing with a completion frees the bank before the completion claims it.
   assign pend_busy     = frame_pending & ~frame_ack;
   assign debug_signal  = {state, idx, wr_bank, frame_pending, timeout_cnt};

   always_comb begin
      complete_c = 1'b0;
`ifdef MCBSP0_RX_CHKSUM_EN
      if (state == S_CHECK && rx_vaild_in && rx_data_in == xor_acc)
         complete_c = 1'b1;
`else
      if (state == S_PAYLOAD && rx_vaild_in && last_word)
         complete_c = 1'b1;
`endif
   end

`ifndef MCBSP0_RX_CHKSUM_EN
   assign err_chksum = 1'b0;
`endif

   always_ff @(posedge mcbsp_slaver_clkx or posedge mcbsp_slaver_rst) begin
      if (mcbsp_slaver_rst) begin
         state         <= S_IDLE;
         idx           <= '0;
         n_words       <= '0;
         cur_type      <= '0;
         wr_bank       <= 1'b0;
         timeout_cnt   <= '0;
         buf_wr_en     <= 1'b0;
         buf_wr_addr   <= '0;
         buf_wr_data   <= '0;
         frame_done    <= 1'b0;
         frame_bank    <= 1'b0;
         frame_type    <= '0;
         frame_words   <= '0;
         frame_pending <= 1'b0;
         err_hdr       <= 1'b0;
         err_timeout   <= 1'b0;
         err_overrun   <= 1'b0;
`ifdef MCBSP0_RX_CHKSUM_EN
         err_chksum    <= 1'b0;
         xor_acc       <= '0;
`endif
      end else begin
         buf_wr_en   <= 1'b0;
         frame_done  <= 1'b0;
         err_hdr     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
`ifdef MCBSP0_RX_CHKSUM_EN
         err_chksum  <= 1'b0;
`endif

         if (frame_ack)
            frame_pending <= 1'b0;

         if (complete_c) begin
            if (!pend_busy) begin
               frame_done    <= 1'b1;
               frame_bank    <= wr_bank;
               frame_type    <= cur_type;
               frame_words   <= n_words;
               frame_pending <= 1'b1;
               wr_bank       <= ~wr_bank;
            end else begin
               err_overrun   <= 1'b1;
            end
         end

         // Inter-word watchdog, active only while inside a frame.
         if (state == S_IDLE) begin
            timeout_cnt <= '0;
         end else if (rx_vaild_in) begin
            timeout_cnt <= '0;
         end else if (timeout_cnt == TMO_TC) begin
            timeout_cnt <= '0;
            err_timeout <= 1'b1;
            state       <= S_IDLE;
         end else begin
            timeout_cnt <= timeout_cnt + 18'd1;
         end

         case (state)
            S_IDLE: begin
               if (rx_vaild_in) begin
                  if (hdr_ok) begin
                     cur_type <= rx_data_in[23:16];
                     n_words  <= rx_data_in[8:0];
                     idx      <= '0;
`ifdef MCBSP0_RX_CHKSUM_EN
                     xor_acc  <= rx_data_in;
`endif
                     state    <= S_PAYLOAD;
                  end else begin
                     err_hdr  <= 1'b1;
                  end
               end
            end
            S_PAYLOAD: begin
               if (rx_vaild_in) begin
                  buf_wr_en   <= 1'b1;
                  buf_wr_addr <= {wr_bank, idx};
                  buf_wr_data <= rx_data_in;
                  idx         <= idx + 9'd1;
`ifdef MCBSP0_RX_CHKSUM_EN
                  xor_acc     <= xor_acc ^ rx_data_in;
                  if (last_word)
                     state <= S_CHECK;
`else
                  if (last_word)
                     state <= S_IDLE;
`endif
               end
            end
`ifdef MCBSP0_RX_CHKSUM_EN
            S_CHECK: begin
               if (rx_vaild_in) begin
                  if (rx_data_in != xor_acc)
                     err_chksum <= 1'b1;
                  state <= S_IDLE;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
